// File: rtl/de_wc_pkg.sv
// ============================================================================
// Module      : de_wc_pkg
// Description : Shared types, widths and helpers for the display-engine write
//               combiner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package de_wc_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;
    localparam int LANES  = DATA_W / 8;

    localparam logic [LANES-1:0] NBYTE_NONE = 4'b1111;
    localparam logic [LANES-1:0] NBYTE_ALL  = 4'b0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_READ  = 2'd3
    } wc_state_e;

    // Zero every byte lane whose valid bit is clear.
    function automatic logic [DATA_W-1:0] mask_lanes(input logic [DATA_W-1:0] data,
                                                     input logic [LANES-1:0]  valid);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            if (valid[i]) r[8*i +: 8] = data[8*i +: 8];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/de_write_combiner_if.sv
// ============================================================================
// Module      : de_write_combiner_if
// Description : Display-engine port, frame-store port and flush/empty status
//               of the write combiner. slave = combiner view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface de_write_combiner_if;
    import de_wc_pkg::*;

    logic                de_req;
    logic                de_ack;
    logic [ADDR_W-1:0]   de_addr;
    logic [LANES-1:0]    de_nbyte;
    logic                de_rnw;
    logic [DATA_W-1:0]   de_w_data;
    logic [DATA_W-1:0]   de_r_data;
    logic                flush;
    logic                empty;
    logic                mem_req;
    logic                mem_ack;
    logic [ADDR_W-1:0]   mem_addr;
    logic [LANES-1:0]    mem_nbyte;
    logic                mem_rnw;
    logic [DATA_W-1:0]   mem_w_data;
    logic [DATA_W-1:0]   mem_r_data;

    modport slave (
        input  de_req, de_addr, de_nbyte, de_rnw, de_w_data, flush, mem_ack, mem_r_data,
        output de_ack, de_r_data, empty, mem_req, mem_addr, mem_nbyte, mem_rnw, mem_w_data
    );

    modport master (
        output de_req, de_addr, de_nbyte, de_rnw, de_w_data, flush, mem_ack, mem_r_data,
        input  de_ack, de_r_data, empty, mem_req, mem_addr, mem_nbyte, mem_rnw, mem_w_data
    );
endinterface

`default_nettype wire

// File: rtl/de_wc_lane_merge.sv
// ============================================================================
// Module      : de_wc_lane_merge
// Description : Combinational byte-lane merge of the buffered word with an
//               incoming active-low-enabled write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module de_wc_lane_merge
    import de_wc_pkg::*;
(
    input  logic [DATA_W-1:0] i_buf_data,
    input  logic [LANES-1:0]  i_buf_mask,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic [LANES-1:0]  i_in_nbyte,
    output logic [DATA_W-1:0] o_merged_data,
    output logic [LANES-1:0]  o_merged_mask,
    output logic              o_full
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign o_merged_data[8*i +: 8] = i_in_nbyte[i] ? i_buf_data[8*i +: 8]
                                                       : i_in_data[8*i +: 8];
        assign o_merged_mask[i]        = i_buf_mask[i] | ~i_in_nbyte[i];
    end

    assign o_full = &o_merged_mask;

endmodule

`default_nettype wire

// File: rtl/de_write_combiner.sv
// ============================================================================
// Module      : de_write_combiner
// Description : Write-combining buffer between the draw engine and the frame
//               store. Optional idle-timeout flush: DE_WC_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module de_write_combiner
    import de_wc_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    de_write_combiner_if.slave bus
);

    wc_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0]  buf_data_q, buf_data_d;
    logic [LANES-1:0]   buf_mask_q, buf_mask_d;
    logic               de_ack_q, de_ack_d;
    logic [DATA_W-1:0]  de_r_data_q, de_r_data_d;
    logic               mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [LANES-1:0]   mem_nbyte_q, mem_nbyte_d;
    logic               mem_rnw_q, mem_rnw_d;
    logic [DATA_W-1:0]  mem_w_data_q, mem_w_data_d;

    logic               w_req_v;
    logic               w_wr;
    logic               w_rd;
    logic               w_wr_null;
    logic               w_wr_data;
    logic               w_same_addr;
    logic               w_mem_done;
    logic               w_timeout;
    logic [DATA_W-1:0]  w_merged_data;
    logic [LANES-1:0]   w_merged_mask;
    logic               w_full;

    // The requester holds de_req through the ack cycle, so ignore it there.
    assign w_req_v     = bus.de_req && !de_ack_q;
    assign w_wr        = w_req_v && !bus.de_rnw;
    assign w_rd        = w_req_v &&  bus.de_rnw;
    assign w_wr_null   = w_wr && (bus.de_nbyte == NBYTE_NONE);
    assign w_wr_data   = w_wr && (bus.de_nbyte != NBYTE_NONE);
    assign w_same_addr = (bus.de_addr == buf_addr_q);
    assign w_mem_done  = mem_req_q && bus.mem_ack;

    // Invalid lanes of the buffer are kept at zero, so merging into an empty
    // buffer is the same operation as capturing a fresh write.
    de_wc_lane_merge u_lane_merge (
        .i_buf_data    (buf_data_q),
        .i_buf_mask    (buf_mask_q),
        .i_in_data     (bus.de_w_data),
        .i_in_nbyte    (bus.de_nbyte),
        .o_merged_data (w_merged_data),
        .o_merged_mask (w_merged_mask),
        .o_full        (w_full)
    );

`ifdef DE_WC_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [7:0] idle_cnt_q, idle_cnt_d;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        w_timeout  = 1'b0;
        if (state_q != ST_HOLD || w_wr) begin
            idle_cnt_d = 8'd0;
        end else if (!bus.de_req) begin
            idle_cnt_d = idle_cnt_q + 8'd1;
            w_timeout  = (idle_cnt_d == TIMEOUT_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) idle_cnt_q <= 8'd0;
        else     idle_cnt_q <= idle_cnt_d;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        buf_addr_d   = buf_addr_q;
        buf_data_d   = buf_data_q;
        buf_mask_d   = buf_mask_q;
        de_ack_d     = 1'b0;
        de_r_data_d  = de_r_data_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        mem_nbyte_d  = mem_nbyte_q;
        mem_rnw_d    = mem_rnw_q;
        mem_w_data_d = mem_w_data_q;

        case (state_q)
            ST_EMPTY: begin
                if (w_wr_null) begin
                    de_ack_d = 1'b1;
                end else if (w_wr_data) begin
                    buf_addr_d = bus.de_addr;
                    buf_data_d = w_merged_data;
                    buf_mask_d = w_merged_mask;
                    de_ack_d   = 1'b1;
                    state_d    = ST_HOLD;
                end else if (w_rd) begin
                    state_d = ST_READ;
                end
            end

            ST_HOLD: begin
                if (w_wr_null) begin
                    de_ack_d = 1'b1;
                end else if (w_wr_data && w_same_addr) begin
                    buf_data_d = w_merged_data;
                    buf_mask_d = w_merged_mask;
                    de_ack_d   = 1'b1;
                end
                // A different-address write or a read stays unacknowledged and
                // is taken from EMPTY once the buffer is written out.
                if ((w_wr_data && (w_full || !w_same_addr)) || w_rd || bus.flush || w_timeout) begin
                    state_d = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                if (!mem_req_q) begin
                    mem_req_d    = 1'b1;
                    mem_rnw_d    = 1'b0;
                    mem_addr_d   = buf_addr_q;
                    mem_nbyte_d  = ~buf_mask_q;
                    mem_w_data_d = mask_lanes(buf_data_q, buf_mask_q);
                end else if (w_mem_done) begin
                    mem_req_d  = 1'b0;
                    buf_data_d = '0;
                    buf_mask_d = '0;
                    state_d    = ST_EMPTY;
                end
            end

            ST_READ: begin
                if (!mem_req_q) begin
                    mem_req_d    = 1'b1;
                    mem_rnw_d    = 1'b1;
                    mem_addr_d   = bus.de_addr;
                    mem_nbyte_d  = NBYTE_ALL;
                    mem_w_data_d = '0;
                end else if (w_mem_done) begin
                    mem_req_d   = 1'b0;
                    de_r_data_d = bus.mem_r_data;
                    de_ack_d    = 1'b1;
                    state_d     = ST_EMPTY;
                end
            end

            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            buf_addr_q   <= '0;
            buf_data_q   <= '0;
            buf_mask_q   <= '0;
            de_ack_q     <= 1'b0;
            de_r_data_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_nbyte_q  <= NBYTE_NONE;
            mem_rnw_q    <= 1'b0;
            mem_w_data_q <= '0;
        end else begin
            state_q      <= state_d;
            buf_addr_q   <= buf_addr_d;
            buf_data_q   <= buf_data_d;
            buf_mask_q   <= buf_mask_d;
            de_ack_q     <= de_ack_d;
            de_r_data_q  <= de_r_data_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_nbyte_q  <= mem_nbyte_d;
            mem_rnw_q    <= mem_rnw_d;
            mem_w_data_q <= mem_w_data_d;
        end
    end

    assign bus.de_ack     = de_ack_q;
    assign bus.de_r_data  = de_r_data_q;
    assign bus.empty      = (state_q == ST_EMPTY);
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_nbyte  = mem_nbyte_q;
    assign bus.mem_rnw    = mem_rnw_q;
    assign bus.mem_w_data = mem_w_data_q;

endmodule

`default_nettype wire

// File: tb/tb_de_write_combiner.sv
// ============================================================================
// Module      : tb_de_write_combiner
// Description : Self-checking bench for de_write_combiner with a frame-store
//               responder model and a byte-level reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_de_write_combiner;
    import de_wc_pkg::*;

    localparam int TIMEOUT = 16;

    typedef struct {
        logic [17:0] addr;
        logic [3:0]  nbyte;
        logic        rnw;
        logic [31:0] wdata;
    } mem_txn_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    mem_txn_t    mlog[$];
    logic [31:0] mem_arr [logic [17:0]];
    bit          resp_en = 1'b1;
    int          inject_req = 0;
    int          inject_done = 0;
    int          ack_log_size = 0;

    always #5 clk = ~clk;

    de_write_combiner_if bus ();

    de_write_combiner #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] rd_mem(input logic [17:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_txn(input string tag, input int idx, input logic [17:0] a,
                           input logic [3:0] nb, input logic rnw, input logic [31:0] wd);
        if (idx < mlog.size()) begin
            chk({tag, "_addr"}, mlog[idx].addr, a);
            chk({tag, "_nbyte"}, mlog[idx].nbyte, nb);
            chk({tag, "_rnw"}, mlog[idx].rnw, rnw);
            if (!rnw) chk({tag, "_wdata"}, mlog[idx].wdata, wd);
        end else begin
            chk({tag, "_present"}, mlog.size(), idx + 1);
        end
    endtask

    // Frame-store responder: random latency, one-cycle mem_ack.
    initial begin : p_mem
        int lat;
        mem_txn_t t;
        logic [31:0] w;
        bus.mem_ack    = 1'b0;
        bus.mem_r_data = '0;
        lat = 1;
        forever begin
            @(posedge clk); #1;
            if (inject_req != inject_done) begin
                bus.mem_ack = 1'b1;
                inject_done = inject_req;
            end else if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
            end else if (resp_en && bus.mem_req) begin
                if (lat > 0) begin
                    lat--;
                end else begin
                    t.addr  = bus.mem_addr;
                    t.nbyte = bus.mem_nbyte;
                    t.rnw   = bus.mem_rnw;
                    t.wdata = bus.mem_w_data;
                    mlog.push_back(t);
                    if (t.rnw) begin
                        bus.mem_r_data = rd_mem(t.addr);
                    end else begin
                        w = rd_mem(t.addr);
                        for (int i = 0; i < 4; i++)
                            if (!t.nbyte[i]) w[8*i +: 8] = t.wdata[8*i +: 8];
                        mem_arr[t.addr] = w;
                    end
                    bus.mem_ack = 1'b1;
                    lat = $urandom_range(0, 3);
                end
            end
        end
    end

    task automatic de_op(input logic [17:0] a, input logic [3:0] nb, input logic rnw,
                         input logic [31:0] wd, output logic [31:0] rd);
        int n;
        n = 0;
        bus.de_addr   = a;
        bus.de_nbyte  = nb;
        bus.de_rnw    = rnw;
        bus.de_w_data = wd;
        bus.de_req    = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.de_ack && n < 300);
        chk($sformatf("de_ack_%0h", a), bus.de_ack, 1'b1);
        rd = bus.de_r_data;
        ack_log_size = mlog.size();
        @(posedge clk); #1;
        chk("de_ack_one_cycle", bus.de_ack, 1'b0);
        bus.de_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(bus.empty && !bus.mem_req && !bus.mem_ack) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_idle"}, bus.empty, 1'b1);
    endtask

    initial begin : p_main
        logic [31:0] rd;
        logic [31:0] ref_mem [4];
        int base;
        int n;
        int acks;

        rst = 1'b1;
        bus.de_req = 1'b0; bus.de_addr = '0; bus.de_nbyte = 4'hF;
        bus.de_rnw = 1'b0; bus.de_w_data = '0; bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_de_ack", bus.de_ack, 1'b0);
        chk("rst_de_r_data", bus.de_r_data, 32'h0);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 18'h0);
        chk("rst_mem_rnw", bus.mem_rnw, 1'b0);
        chk("rst_mem_w_data", bus.mem_w_data, 32'h0);
        chk("rst_mem_nbyte", bus.mem_nbyte, 4'b1111);
        chk("rst_empty", bus.empty, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Four lanes of one word combine into a single full write.
        base = mlog.size();
        de_op(18'h00010, 4'b1110, 1'b0, 32'h00000011, rd);
        de_op(18'h00010, 4'b1101, 1'b0, 32'h00002200, rd);
        de_op(18'h00010, 4'b1011, 1'b0, 32'h00330000, rd);
        de_op(18'h00010, 4'b0111, 1'b0, 32'h44000000, rd);
        wait_idle("full");
        chk("full_count", mlog.size() - base, 1);
        chk_txn("full", base, 18'h00010, 4'b0000, 1'b0, 32'h44332211);

        // Address change flushes the old word before the new write is acked.
        base = mlog.size();
        de_op(18'h00010, 4'b1110, 1'b0, 32'h000000AA, rd);
        de_op(18'h00011, 4'b1101, 1'b0, 32'h0000BB00, rd);
        chk("chg_before_ack", ack_log_size - base, 1);
        chk_txn("chg_old", base, 18'h00010, 4'b1110, 1'b0, 32'h000000AA);
        chk("chg_buffered", bus.empty, 1'b0);
        bus.flush = 1'b1;
        wait_idle("chg");
        bus.flush = 1'b0;
        chk_txn("chg_new", base + 1, 18'h00011, 4'b1101, 1'b0, 32'h0000BB00);

        // Idle timeout (or its absence).
        base = mlog.size();
        de_op(18'h00500, 4'b1011, 1'b0, 32'h00AB0000, rd);
        n = 1;
        while (!bus.mem_req && n < 120) begin
            @(posedge clk); #1;
            n++;
        end
`ifdef DE_WC_TIMEOUT_EN
        chk("timeout_latency_17_18", (n >= 17 && n <= 18), 1'b1);
`else
        chk("no_timeout_mem_req", bus.mem_req, 1'b0);
        bus.flush = 1'b1;
`endif
        wait_idle("timeout");
        bus.flush = 1'b0;
        chk_txn("timeout", base, 18'h00500, 4'b1011, 1'b0, 32'h00AB0000);

        // Read of a dirty word: the flush precedes the read.
        base = mlog.size();
        de_op(18'h00200, 4'b1011, 1'b0, 32'h005C0000, rd);
        de_op(18'h00200, 4'b0000, 1'b1, 32'h0, rd);
        chk("rd_data", rd, 32'h005C0000);
        chk_txn("rd_flush", base, 18'h00200, 4'b1011, 1'b0, 32'h005C0000);
        chk_txn("rd_read", base + 1, 18'h00200, 4'b0000, 1'b1, 32'h0);

        // Later lane value overwrites the earlier one; external flush.
        base = mlog.size();
        de_op(18'h00300, 4'b1110, 1'b0, 32'h00000001, rd);
        de_op(18'h00300, 4'b1110, 1'b0, 32'h00000002, rd);
        bus.flush = 1'b1;
        wait_idle("ovw");
        bus.flush = 1'b0;
        chk_txn("ovw", base, 18'h00300, 4'b1110, 1'b0, 32'h00000002);

        // Write with no lanes enabled: acked, nothing buffered.
        base = mlog.size();
        de_op(18'h00600, 4'b1111, 1'b0, 32'hFFFFFFFF, rd);
        chk("null_empty", bus.empty, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("null_no_mem", mlog.size() - base, 0);

        // Reset while the flush write is outstanding; a late ack is ignored.
        de_op(18'h00400, 4'b1110, 1'b0, 32'h00000077, rd);
        resp_en = 1'b0;
        bus.flush = 1'b1;
        n = 0;
        while (!bus.mem_req && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rstf_mem_req_up", bus.mem_req, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstf_mem_req", bus.mem_req, 1'b0);
        chk("rstf_empty", bus.empty, 1'b1);
        rst = 1'b0;
        bus.flush = 1'b0;
        inject_req++;
        acks = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.de_ack || bus.mem_req) acks++;
        end
        chk("rstf_late_ack", acks, 0);
        chk("rstf_still_empty", bus.empty, 1'b1);
        resp_en = 1'b1;

        // Randomized traffic against a byte-level reference memory.
        for (int i = 0; i < 4; i++) ref_mem[i] = 32'h0;
        for (int k = 0; k < 80; k++) begin
            int          ai;
            logic [3:0]  nb;
            logic [31:0] wd;
            ai = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
                de_op(18'h01000 + 18'(ai), 4'b0000, 1'b1, 32'h0, rd);
                chk($sformatf("rand_rd_%0d", k), rd, ref_mem[ai]);
            end else begin
                nb = 4'($urandom);
                wd = $urandom;
                de_op(18'h01000 + 18'(ai), nb, 1'b0, wd, rd);
                for (int l = 0; l < 4; l++)
                    if (!nb[l]) ref_mem[ai][8*l +: 8] = wd[8*l +: 8];
            end
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        wait_idle("rand");
        bus.flush = 1'b0;
        for (int i = 0; i < 4; i++)
            chk($sformatf("rand_mem_%0d", i), rd_mem(18'h01000 + 18'(i)), ref_mem[i]);
        for (int j = 0; j < mlog.size(); j++)
            if (!mlog[j].rnw)
                for (int l = 0; l < 4; l++)
                    if (mlog[j].nbyte[l]) chk("idle_lane_zero", mlog[j].wdata[8*l +: 8], 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
